// File: rtl/vx_result_gather.sv
// Reassembles pid-indexed narrow result packets of one instruction into a
// single full-warp writeback beat, presented on a registered valid/ready port.
module vx_result_gather #(
  parameter int NUM_THREADS   = 4,
  parameter int NUM_LANES     = 2,
  parameter int XLEN          = 32,
  parameter int NW_WIDTH      = 2,
  parameter int UUID_WIDTH    = 44,
  parameter int PC_BITS       = 30,
  parameter int NUM_REGS_BITS = 6,
  parameter int PID_WIDTH     = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [PC_BITS-1:0]          in_PC,
  input  logic                        in_wb,
  input  logic [NUM_REGS_BITS-1:0]    in_rd,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [PC_BITS-1:0]          out_PC,
  output logic                        out_wb,
  output logic [NUM_REGS_BITS-1:0]    out_rd,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  input  logic                        out_ready,
  output logic                        proto_err
);

  localparam int NUM_PKTS = NUM_THREADS / NUM_LANES;

  typedef enum logic {IDLE, GATHER} state_e;

  state_e                      state_q, state_d;
  logic [NUM_THREADS-1:0]      acc_tmask_q, acc_tmask_d;
  logic [NUM_THREADS*XLEN-1:0] acc_data_q, acc_data_d;
  logic [UUID_WIDTH-1:0]       hdr_uuid_q, hdr_uuid_d;
  logic [NW_WIDTH-1:0]         hdr_wid_q, hdr_wid_d;
  logic [PC_BITS-1:0]          hdr_pc_q, hdr_pc_d;
  logic                        hdr_wb_q, hdr_wb_d;
  logic [NUM_REGS_BITS-1:0]    hdr_rd_q, hdr_rd_d;

  logic                        out_valid_q, out_valid_d;
  logic [UUID_WIDTH-1:0]       out_uuid_q, out_uuid_d;
  logic [NW_WIDTH-1:0]         out_wid_q, out_wid_d;
  logic [NUM_THREADS-1:0]      out_tmask_q, out_tmask_d;
  logic [PC_BITS-1:0]          out_pc_q, out_pc_d;
  logic                        out_wb_q, out_wb_d;
  logic [NUM_REGS_BITS-1:0]    out_rd_q, out_rd_d;
  logic [NUM_THREADS*XLEN-1:0] out_data_q, out_data_d;
  logic                        err_q, err_d;

  logic                        fire;
  logic                        sop_eff, eop_eff, fmt_err;
  logic [PID_WIDTH-1:0]        pid_eff;
  logic [NUM_THREADS-1:0]      wr_en, wr_tmask, base_tmask, mrg_tmask;
  logic [NUM_THREADS*XLEN-1:0] wr_data, base_data, mrg_data;

  assign in_ready = !out_valid_q || out_ready;
  assign fire     = in_valid && in_ready;

  // With one packet per warp every packet is a complete instruction; pid and
  // framing are ignored for placement, bad framing is only flagged.
  generate
    if (NUM_PKTS == 1) begin : g_single
      assign pid_eff = '0;
      assign sop_eff = 1'b1;
      assign eop_eff = 1'b1;
      assign fmt_err = !(in_sop && in_eop);
    end else begin : g_multi
      assign pid_eff = in_pid;
      assign sop_eff = in_sop;
      assign eop_eff = in_eop;
      assign fmt_err = 1'b0;
    end
  endgenerate

  // Scatter packet lanes to their thread slots; inactive lanes contribute zero data.
  always_comb begin
    wr_en    = '0;
    wr_tmask = '0;
    wr_data  = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if ((t / NUM_LANES) == 32'(pid_eff)) begin
        wr_en[t]    = 1'b1;
        wr_tmask[t] = in_tmask[t % NUM_LANES];
        if (in_tmask[t % NUM_LANES])
          wr_data[t*XLEN +: XLEN] = in_data[(t % NUM_LANES)*XLEN +: XLEN];
      end
    end
  end

  // A sop packet always merges into a cleared accumulator.
  assign base_tmask = sop_eff ? '0 : acc_tmask_q;
  assign base_data  = sop_eff ? '0 : acc_data_q;
  assign mrg_tmask  = (base_tmask & ~wr_en) | wr_tmask;

  always_comb begin
    mrg_data = base_data;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (wr_en[t])
        mrg_data[t*XLEN +: XLEN] = wr_data[t*XLEN +: XLEN];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_tmask_d = acc_tmask_q;
    acc_data_d  = acc_data_q;
    hdr_uuid_d  = hdr_uuid_q;
    hdr_wid_d   = hdr_wid_q;
    hdr_pc_d    = hdr_pc_q;
    hdr_wb_d    = hdr_wb_q;
    hdr_rd_d    = hdr_rd_q;
    out_valid_d = out_valid_q;
    out_uuid_d  = out_uuid_q;
    out_wid_d   = out_wid_q;
    out_tmask_d = out_tmask_q;
    out_pc_d    = out_pc_q;
    out_wb_d    = out_wb_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_uuid_d  = '0;
      out_wid_d   = '0;
      out_tmask_d = '0;
      out_pc_d    = '0;
      out_wb_d    = 1'b0;
      out_rd_d    = '0;
      out_data_d  = '0;
    end

    // A load below overrides the handshake clear, giving back-to-back beats.
    if (fire) begin
      if (fmt_err)
        err_d = 1'b1;
      if (state_q == GATHER && in_wid != hdr_wid_q)
        err_d = 1'b1;

      if (sop_eff) begin
        if (state_q == GATHER)
          err_d = 1'b1;
        if (eop_eff) begin
          out_valid_d = 1'b1;
          out_uuid_d  = in_uuid;
          out_wid_d   = in_wid;
          out_pc_d    = in_PC;
          out_wb_d    = in_wb;
          out_rd_d    = in_rd;
          out_tmask_d = mrg_tmask;
          out_data_d  = mrg_data;
          acc_tmask_d = '0;
          acc_data_d  = '0;
          state_d     = IDLE;
        end else begin
          hdr_uuid_d  = in_uuid;
          hdr_wid_d   = in_wid;
          hdr_pc_d    = in_PC;
          hdr_wb_d    = in_wb;
          hdr_rd_d    = in_rd;
          acc_tmask_d = mrg_tmask;
          acc_data_d  = mrg_data;
          state_d     = GATHER;
        end
      end else if (state_q == GATHER) begin
        if (eop_eff) begin
          out_valid_d = 1'b1;
          out_uuid_d  = hdr_uuid_q;
          out_wid_d   = hdr_wid_q;
          out_pc_d    = hdr_pc_q;
          out_wb_d    = hdr_wb_q;
          out_rd_d    = hdr_rd_q;
          out_tmask_d = mrg_tmask;
          out_data_d  = mrg_data;
          acc_tmask_d = '0;
          acc_data_d  = '0;
          state_d     = IDLE;
        end else begin
          acc_tmask_d = mrg_tmask;
          acc_data_d  = mrg_data;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_tmask_q <= '0;
      acc_data_q  <= '0;
      hdr_uuid_q  <= '0;
      hdr_wid_q   <= '0;
      hdr_pc_q    <= '0;
      hdr_wb_q    <= 1'b0;
      hdr_rd_q    <= '0;
      out_valid_q <= 1'b0;
      out_uuid_q  <= '0;
      out_wid_q   <= '0;
      out_tmask_q <= '0;
      out_pc_q    <= '0;
      out_wb_q    <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_tmask_q <= acc_tmask_d;
      acc_data_q  <= acc_data_d;
      hdr_uuid_q  <= hdr_uuid_d;
      hdr_wid_q   <= hdr_wid_d;
      hdr_pc_q    <= hdr_pc_d;
      hdr_wb_q    <= hdr_wb_d;
      hdr_rd_q    <= hdr_rd_d;
      out_valid_q <= out_valid_d;
      out_uuid_q  <= out_uuid_d;
      out_wid_q   <= out_wid_d;
      out_tmask_q <= out_tmask_d;
      out_pc_q    <= out_pc_d;
      out_wb_q    <= out_wb_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_uuid  = out_uuid_q;
  assign out_wid   = out_wid_q;
  assign out_tmask = out_tmask_q;
  assign out_PC    = out_pc_q;
  assign out_wb    = out_wb_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;
  assign proto_err = err_q;

endmodule
